rst_seq: RTL

Parametrised reset sequencer, the successor to the single-output PLL-lock reset generator in the system manager. It synchronises the PLL lock indication, holds every reset domain asserted for a programmable time after lock, then releases N_OUT reset outputs in order, spaced by a fixed gap. It re-runs the sequence on loss of lock or on a software reset request, and it counts lock-loss events for debug. It sits in the system manager between the PLL and the per-domain global reset buffers.

---
 rtl/rst_seq_pkg.sv | 18 +
 rtl/sync_bit.sv | 23 ++
 rtl/rst_seq.sv | 119 +++++++++++
 3 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the staged reset sequencer.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int LOST_W = 8;

    // Lock-loss counter sticks at all-ones instead of wrapping.
    function automatic logic [LOST_W-1:0] sat_inc(input logic [LOST_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Single-bit multi-flop synchroniser with synchronous clear.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic srst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            chain_reg <= '0;
        end else begin
            chain_reg <= {chain_reg[STAGES-2:0], d};
        end
    end

    assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: waits for synchronised PLL lock, holds, then releases
// N_OUT reset domains in index order; restarts on lock loss or soft request.
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int N_OUT       = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pll_lock,
    input  logic              soft_rst_req,
    output logic [N_OUT-1:0]  rst_out,
    output logic              ready,
    output logic [LOST_W-1:0] lost_cnt
);

    localparam int CNT_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int STG_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [STG_W-1:0] STG_LAST  = STG_W'(N_OUT - 1);
    localparam logic [N_OUT-1:0] STG_ONE   = N_OUT'(1);

    logic              lock_s;
    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [STG_W-1:0]  stg_reg;
    logic [N_OUT-1:0]  rst_out_reg;
    logic              ready_reg;
    logic [LOST_W-1:0] lost_reg;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk  (clk),
        .srst (rst),
        .d    (pll_lock),
        .q    (lock_s)
    );

    // Counters only ever compare for equality with their terminal value and
    // are cleared on every state change, so they never need to wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= WAIT_LOCK;
            cnt_reg     <= '0;
            stg_reg     <= '0;
            rst_out_reg <= '1;
            ready_reg   <= 1'b0;
            lost_reg    <= '0;
        end else if (!lock_s && state_reg != WAIT_LOCK) begin
            state_reg   <= WAIT_LOCK;
            cnt_reg     <= '0;
            stg_reg     <= '0;
            rst_out_reg <= '1;
            ready_reg   <= 1'b0;
            lost_reg    <= sat_inc(lost_reg);
        end else if (soft_rst_req && (state_reg == RELEASE || state_reg == RUN)) begin
            state_reg   <= HOLD;
            cnt_reg     <= '0;
            stg_reg     <= '0;
            rst_out_reg <= '1;
            ready_reg   <= 1'b0;
        end else begin
            case (state_reg)
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_reg <= HOLD;
                        cnt_reg   <= '0;
                    end
                end
                HOLD: begin
                    if (cnt_reg == HOLD_LAST) begin
                        cnt_reg        <= '0;
                        rst_out_reg[0] <= 1'b0;
                        if (N_OUT == 1) begin
                            state_reg <= RUN;
                            ready_reg <= 1'b1;
                        end else begin
                            state_reg <= RELEASE;
                            stg_reg   <= STG_W'(1);
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                RELEASE: begin
                    if (cnt_reg == GAP_LAST) begin
                        cnt_reg     <= '0;
                        rst_out_reg <= rst_out_reg & ~(STG_ONE << stg_reg);
                        if (stg_reg == STG_LAST) begin
                            state_reg <= RUN;
                            ready_reg <= 1'b1;
                        end else begin
                            stg_reg <= stg_reg + 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                RUN: begin
                end
                default: begin
                    state_reg <= WAIT_LOCK;
                end
            endcase
        end
    end

    assign rst_out  = rst_out_reg;
    assign ready    = ready_reg;
    assign lost_cnt = lost_reg;

endmodule
